ballot_collector: RTL and testbench

Upstream stage of the multi-class vote evaluator. It accepts individual ballots one per cycle over a valid/ready handshake and accumulates them into the np/vip/vvip yes-vectors. When voting closes, either by strobe or by timeout, it freezes and presents the vectors with out_valid until the consumer acknowledges. It also flags duplicate and malformed ballots.

---
 rtl/ballot_collector_pkg.sv | 16 +
 rtl/ballot_collector_decode.sv | 54 +++++
 rtl/ballot_collector.sv | 155 +++++++++++++++
 tb/tb_ballot_collector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ballot_collector_pkg.sv
// Shared encodings for the ballot collector and the downstream vote evaluator:
// voter class codes and the collector's round-state encoding.
package ballot_collector_pkg;

   localparam logic [1:0] CLS_NP   = 2'd0;
   localparam logic [1:0] CLS_VIP  = 2'd1;
   localparam logic [1:0] CLS_VVIP = 2'd2;
   localparam logic [1:0] CLS_RSV  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/ballot_collector_decode.sv
// Combinational ballot decoder: maps class/index onto a one-hot bit of the
// concatenated voted mask {vvip, vip, np}, and flags malformed ballots and
// ballots from voters whose mask bit is already set.
module ballot_decode
   import ballot_collector_pkg::*;
#(
   parameter int NP_W   = 32,
   parameter int VIP_W  = 8,
   parameter int MASK_W = NP_W + VIP_W + 1
) (
   input  logic [1:0]        cls,
   input  logic [4:0]        idx,
   input  logic [MASK_W-1:0] voted,
   output logic [MASK_W-1:0] set_en,
   output logic              malformed,
   output logic              duplicate
);

   localparam logic [MASK_W-1:0] ONE = MASK_W'(1);

   // Decode the ballot into its mask position; out-of-range ballots select nothing.
   always_comb begin
      set_en    = '0;
      malformed = 1'b0;
      case (cls)
         CLS_NP: begin
            if (int'(idx) < NP_W) begin
               set_en = ONE << int'(idx);
            end else begin
               malformed = 1'b1;
            end
         end
         CLS_VIP: begin
            if (int'(idx) < VIP_W) begin
               set_en = ONE << (NP_W + int'(idx));
            end else begin
               malformed = 1'b1;
            end
         end
         CLS_VVIP: begin
            if (idx == 5'd0) begin
               set_en = ONE << (MASK_W - 1);
            end else begin
               malformed = 1'b1;
            end
         end
         default: begin
            malformed = 1'b1;
         end
      endcase
      duplicate = |(set_en & voted);
   end

endmodule

// File: rtl/ballot_collector.sv
// Ballot collector: opens a voting round on start, accepts one ballot per
// cycle while open, closes on close or timeout, then holds the yes-vectors
// with out_valid until the consumer acknowledges.
module ballot_collector
   import ballot_collector_pkg::*;
#(
   parameter int NP_W    = 32,
   parameter int VIP_W   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_class,
   input  logic [4:0]       in_idx,
   input  logic             in_yes,
   input  logic             close,
   output logic [NP_W-1:0]  np,
   output logic [VIP_W-1:0] vip,
   output logic             vvip,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [5:0]       ballot_cnt,
   output logic             dup_err,
   output logic             bad_err
);

   localparam int MASK_W = NP_W + VIP_W + 1;
   localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

   state_t            state_r;
   state_t            state_next_s;
   logic [MASK_W-1:0] voted_r;
   logic [MASK_W-1:0] vote_r;
   logic [TMO_W-1:0]  tmo_r;
   logic [MASK_W-1:0] set_en_s;
   logic              malformed_s;
   logic              duplicate_s;
   logic              accept_s;
   logic              timeout_s;
   logic              open_start_s;

   ballot_decode #(
      .NP_W   (NP_W),
      .VIP_W  (VIP_W),
      .MASK_W (MASK_W)
   ) u_decode (
      .cls       (in_class),
      .idx       (in_idx),
      .voted     (voted_r),
      .set_en    (set_en_s),
      .malformed (malformed_s),
      .duplicate (duplicate_s)
   );

   assign accept_s     = in_valid & in_ready;
   assign timeout_s    = (TIMEOUT != 0) && (tmo_r == TMO_LAST);
   assign open_start_s = (state_r == IDLE) && start;

   assign np   = vote_r[NP_W-1:0];
   assign vip  = vote_r[NP_W+VIP_W-1:NP_W];
   assign vvip = vote_r[MASK_W-1];

   // Next-state logic: start opens, close/timeout freezes, ack releases.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = OPEN;
            end else begin
               state_next_s = IDLE;
            end
         end
         OPEN: begin
            if (close || timeout_s) begin
               state_next_s = HOLD;
            end else begin
               state_next_s = OPEN;
            end
         end
         HOLD: begin
            if (out_ack) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register with handshake outputs registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         in_ready  <= (state_next_s == OPEN);
         out_valid <= (state_next_s == HOLD);
      end
   end

   // Timeout counter: cleared when a round opens, counts every open cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_r <= '0;
      end else if (open_start_s) begin
         tmo_r <= '0;
      end else if (state_r == OPEN) begin
         tmo_r <= tmo_r + TMO_W'(1);
      end else begin
         tmo_r <= tmo_r;
      end
   end

   // Ballot accumulation: first well-formed vote per voter wins, errors are sticky.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         voted_r    <= '0;
         vote_r     <= '0;
         ballot_cnt <= 6'd0;
         dup_err    <= 1'b0;
         bad_err    <= 1'b0;
      end else if (open_start_s) begin
         voted_r    <= '0;
         vote_r     <= '0;
         ballot_cnt <= 6'd0;
         dup_err    <= 1'b0;
         bad_err    <= 1'b0;
      end else if (accept_s) begin
         if (malformed_s) begin
            bad_err <= 1'b1;
         end else if (duplicate_s) begin
            dup_err <= 1'b1;
         end else begin
            voted_r    <= voted_r | set_en_s;
            vote_r     <= (vote_r & ~set_en_s) | (set_en_s & {MASK_W{in_yes}});
            ballot_cnt <= ballot_cnt + 6'd1;
         end
      end else begin
         voted_r    <= voted_r;
         vote_r     <= vote_r;
         ballot_cnt <= ballot_cnt;
      end
   end

endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench for ballot_collector: directed vector table, timeout and
// asynchronous reset sequences, and randomized traffic against a voter-array model.
module tb_ballot_collector;

   localparam int NP_W    = 32;
   localparam int VIP_W   = 8;
   localparam int TIMEOUT = 16;

   logic             clk;
   logic             reset;
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_class;
   logic [4:0]       in_idx;
   logic             in_yes;
   logic             close;
   logic [NP_W-1:0]  np;
   logic [VIP_W-1:0] vip;
   logic             vvip;
   logic             out_valid;
   logic             out_ack;
   logic [5:0]       ballot_cnt;
   logic             dup_err;
   logic             bad_err;

   int checks = 0;
   int passes = 0;

   ballot_collector #(.NP_W(NP_W), .VIP_W(VIP_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_idx(in_idx), .in_yes(in_yes), .close(close),
      .np(np), .vip(vip), .vvip(vvip), .out_valid(out_valid), .out_ack(out_ack),
      .ballot_cnt(ballot_cnt), .dup_err(dup_err), .bad_err(bad_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per-class voter arrays and a round phase (0 idle, 1 open, 2 hold)
   int m_phase;
   bit m_voted [3][32];
   bit m_yes   [3][32];
   int m_cnt;
   bit m_dup;
   bit m_bad;
   int m_open_cycles;

   function automatic int capacity(input int cls);
      case (cls)
         0: return NP_W;
         1: return VIP_W;
         2: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_dup = 0; m_bad = 0; m_open_cycles = 0;
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 32; i++) begin
            m_voted[c][i] = 0;
            m_yes[c][i] = 0;
         end
   endtask

   task automatic model_edge();
      int c;
      int i;
      c = int'(in_class);
      i = int'(in_idx);
      if (m_phase == 0) begin
         if (start) begin
            model_reset();
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (in_valid) begin
            if (i >= capacity(c)) m_bad = 1;
            else if (m_voted[c][i]) m_dup = 1;
            else begin
               m_voted[c][i] = 1;
               m_yes[c][i] = in_yes;
               m_cnt++;
            end
         end
         if (close || (m_open_cycles == TIMEOUT - 1)) m_phase = 2;
         m_open_cycles++;
      end else begin
         if (out_ack) m_phase = 0;
      end
   endtask

   function automatic logic [63:0] model_outputs();
      logic [NP_W-1:0]  e_np;
      logic [VIP_W-1:0] e_vip;
      e_np = '0;
      e_vip = '0;
      for (int i = 0; i < NP_W; i++) e_np[i] = m_yes[0][i];
      for (int i = 0; i < VIP_W; i++) e_vip[i] = m_yes[1][i];
      return {13'd0, e_np, e_vip, m_yes[2][0], (m_phase == 2), (m_phase == 1),
              6'(m_cnt), m_dup, m_bad};
   endfunction

   function automatic logic [63:0] dut_outputs();
      return {13'd0, np, vip, vvip, out_valid, in_ready, ballot_cnt, dup_err, bad_err};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // One clock cycle: apply inputs, advance model on the edge, compare 1 time unit later
   task automatic drive(input logic s, input logic v, input logic [1:0] c, input logic [4:0] i,
                        input logic y, input logic cl, input logic a);
      start = s; in_valid = v; in_class = c; in_idx = i; in_yes = y; close = cl; out_ack = a;
      @(posedge clk);
      model_edge();
      #1;
      check("model", dut_outputs(), model_outputs());
   endtask

   typedef struct {
      logic s, v; logic [1:0] c; logic [4:0] i; logic y, cl, a;
      logic e_rdy, e_val; logic [5:0] e_cnt; logic e_dup, e_bad;
      logic [31:0] e_np; logic [7:0] e_vip; logic e_vvip;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(input logic s, v, input logic [1:0] c, input logic [4:0] i,
                                input logic y, cl, a, e_rdy, e_val, input logic [5:0] e_cnt,
                                input logic e_dup, e_bad, input logic [31:0] e_np,
                                input logic [7:0] e_vip, input logic e_vvip);
      vec_t r;
      r.s = s; r.v = v; r.c = c; r.i = i; r.y = y; r.cl = cl; r.a = a;
      r.e_rdy = e_rdy; r.e_val = e_val; r.e_cnt = e_cnt; r.e_dup = e_dup; r.e_bad = e_bad;
      r.e_np = e_np; r.e_vip = e_vip; r.e_vvip = e_vvip;
      return r;
   endfunction

   initial begin
      int got_lat;
      bit seen;
      logic [1:0] rc;
      logic [4:0] ri;

      // round 1: four good ballots then close; ack; stray close in IDLE
      tbl.push_back(row(1,0,2'd0,5'd0, 0,0,0, 1,0,6'd0,0,0, 32'h0,       8'h00,0));
      tbl.push_back(row(0,1,2'd0,5'd0, 1,0,0, 1,0,6'd1,0,0, 32'h1,       8'h00,0));
      tbl.push_back(row(0,1,2'd0,5'd31,1,0,0, 1,0,6'd2,0,0, 32'h80000001,8'h00,0));
      tbl.push_back(row(0,1,2'd1,5'd3, 1,0,0, 1,0,6'd3,0,0, 32'h80000001,8'h08,0));
      tbl.push_back(row(0,1,2'd2,5'd0, 1,0,0, 1,0,6'd4,0,0, 32'h80000001,8'h08,1));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,1,0, 0,1,6'd4,0,0, 32'h80000001,8'h08,1));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,0,1, 0,0,6'd4,0,0, 32'h80000001,8'h08,1));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,1,0, 0,0,6'd4,0,0, 32'h80000001,8'h08,1));
      // round 2: duplicate vote, first vote stands
      tbl.push_back(row(1,0,2'd0,5'd0, 0,0,0, 1,0,6'd0,0,0, 32'h0, 8'h00,0));
      tbl.push_back(row(0,1,2'd0,5'd5, 1,0,0, 1,0,6'd1,0,0, 32'h20,8'h00,0));
      tbl.push_back(row(0,1,2'd0,5'd5, 0,0,0, 1,0,6'd1,1,0, 32'h20,8'h00,0));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,1,0, 0,1,6'd1,1,0, 32'h20,8'h00,0));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,0,1, 0,0,6'd1,1,0, 32'h20,8'h00,0));
      // round 3: malformed ballots (ack while OPEN ignored)
      tbl.push_back(row(1,0,2'd0,5'd0, 0,0,0, 1,0,6'd0,0,0, 32'h0,8'h00,0));
      tbl.push_back(row(0,1,2'd1,5'd9, 1,0,0, 1,0,6'd0,0,1, 32'h0,8'h00,0));
      tbl.push_back(row(0,1,2'd2,5'd1, 1,0,1, 1,0,6'd0,0,1, 32'h0,8'h00,0));
      tbl.push_back(row(0,1,2'd3,5'd0, 1,0,0, 1,0,6'd0,0,1, 32'h0,8'h00,0));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,1,0, 0,1,6'd0,0,1, 32'h0,8'h00,0));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,0,1, 0,0,6'd0,0,1, 32'h0,8'h00,0));
      // round 4: ballot with close, HOLD ignores ballot/start, new start clears
      tbl.push_back(row(1,0,2'd0,5'd0, 0,0,0, 1,0,6'd0,0,0, 32'h0, 8'h00,0));
      tbl.push_back(row(0,1,2'd0,5'd7, 1,1,0, 0,1,6'd1,0,0, 32'h80,8'h00,0));
      tbl.push_back(row(1,1,2'd0,5'd2, 1,0,0, 0,1,6'd1,0,0, 32'h80,8'h00,0));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,0,1, 0,0,6'd1,0,0, 32'h80,8'h00,0));
      tbl.push_back(row(1,0,2'd0,5'd0, 0,0,0, 1,0,6'd0,0,0, 32'h0, 8'h00,0));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,1,0, 0,1,6'd0,0,0, 32'h0, 8'h00,0));
      tbl.push_back(row(0,0,2'd0,5'd0, 0,0,1, 0,0,6'd0,0,0, 32'h0, 8'h00,0));

      start = 0; in_valid = 0; in_class = 2'd0; in_idx = 5'd0; in_yes = 0; close = 0; out_ack = 0;
      reset = 1'b0;
      #1 reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", dut_outputs(), 64'd0);
      reset = 1'b0;

      foreach (tbl[k]) begin
         drive(tbl[k].s, tbl[k].v, tbl[k].c, tbl[k].i, tbl[k].y, tbl[k].cl, tbl[k].a);
         check($sformatf("row%0d_ctrl", k),
               {58'd0, in_ready, out_valid, ballot_cnt, dup_err, bad_err},
               {58'd0, tbl[k].e_rdy, tbl[k].e_val, tbl[k].e_cnt, tbl[k].e_dup, tbl[k].e_bad});
         check($sformatf("row%0d_vec", k), {23'd0, np, vip, vvip},
               {23'd0, tbl[k].e_np, tbl[k].e_vip, tbl[k].e_vvip});
      end

      // timeout: no close, out_valid must rise after exactly TIMEOUT open cycles
      drive(1,0,2'd0,5'd0,0,0,0);
      seen = 0;
      got_lat = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         drive(0,0,2'd0,5'd0,0,0,0);
         if (out_valid) begin
            seen = 1;
            got_lat = k;
         end
      end
      check("timeout_latency", 64'(got_lat), 64'd16);
      drive(0,0,2'd0,5'd0,0,0,1);

      // randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         rc = 2'($urandom_range(0, 3));
         case (rc)
            2'd0: ri = 5'($urandom_range(0, 31));
            2'd1: ri = 5'($urandom_range(0, 10));
            2'd2: ri = 5'($urandom_range(0, 1));
            default: ri = 5'($urandom_range(0, 31));
         endcase
         drive(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 70), rc, ri,
               1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 4),
               ($urandom_range(0, 99) < 30));
      end

      // return to IDLE, then reset in the middle of an open round
      drive(0,0,2'd0,5'd0,0,1,0);
      drive(0,0,2'd0,5'd0,0,0,1);
      drive(0,0,2'd0,5'd0,0,0,1);
      drive(1,0,2'd0,5'd0,0,0,0);
      drive(0,1,2'd0,5'd1,1,0,0);
      drive(0,1,2'd1,5'd2,1,0,0);
      drive(0,1,2'd2,5'd0,1,0,0);
      check("pre_reset_cnt", 64'(ballot_cnt), 64'd3);
      start = 0; in_valid = 0; close = 0; out_ack = 0;
      reset = 1'b1;
      #2;
      check("async_reset", dut_outputs(), 64'd0);
      model_reset();
      reset = 1'b0;
      drive(0,1,2'd0,5'd3,1,0,0);
      drive(1,0,2'd0,5'd0,0,0,0);
      drive(0,1,2'd0,5'd3,1,1,0);
      check("post_reset_round", {31'd0, np, ballot_cnt, out_valid}, {31'd0, 32'h8, 6'd1, 1'b1});
      drive(0,0,2'd0,5'd0,0,0,1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
